seq_mult_src: RTL and testbench

- Sequential shift-add unsigned multiplier.
- Produces the 16-bit product stream P consumed by the MAC accumulator, i.e. the producer end of the product interface.
- Accepts one operand pair per transaction through a valid/ready handshake.
- Presents each product with a valid/ready handshake, so the accumulator adds each product exactly once instead of adding on every value change.

---
 rtl/mult_pkg.sv | 9 +
 rtl/shift_add_dp.sv | 39 +++
 rtl/seq_mult_src.sv | 65 ++++++
 tb/tb_seq_mult_src.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and sizing for the shift-add multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int CNT_W = $clog2(DEF_WIDTH + 1);
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/shift_add_dp.sv
// shift_add_dp: multiplicand/multiplier/partial-sum/counter registers
module shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] sum,
    output logic               done_cnt
);
    localparam int CW = cnt_width(WIDTH);
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    assign done_cnt = cnt == CW'(WIDTH);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            sum    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            sum    <= '0;
            cnt    <= '0;
        end else if (step) begin
            sum    <= mplier[0] ? sum + mcand : sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/seq_mult_src.sv
// seq_mult_src: sequential shift-add multiplier with valid/ready on both sides
module seq_mult_src
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               p_valid,
    input  logic               p_ready,
    output logic               busy
);
    state_t             state;
    logic               load;
    logic               step;
    logic               done_cnt;
    logic [2*WIDTH-1:0] sum;
    // The final BUSY cycle only publishes the sum, giving the fixed WIDTH+1 latency
    assign load = (state == IDLE) && in_valid;
    assign step = (state == BUSY) && !done_cnt;
    shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .a        (a),
        .b        (b),
        .sum      (sum),
        .done_cnt (done_cnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            p_valid  <= 1'b0;
            P        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state    <= BUSY;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                BUSY: if (done_cnt) begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    p_valid <= 1'b1;
                    P       <= sum;
                end
                DONE: if (p_ready) begin
                    state    <= IDLE;
                    p_valid  <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_src.sv
// tb_seq_mult_src: scoreboard bench for the shift-add multiplier
module tb_seq_mult_src;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a, b;
    logic        in_valid, in_ready, p_valid, p_ready, busy;
    logic [15:0] P;
    logic [15:0] exp_q[$];
    logic [15:0] want;
    int          checks = 0;
    int          errors = 0;
    int          acc = 0;
    int          hs_n = 0;

    seq_mult_src dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .P(P), .p_valid(p_valid), .p_ready(p_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // downstream accumulator: adds a product only on a completed handshake
    always @(posedge clk) begin
        if (rst_n && p_valid && p_ready) begin
            acc  <= acc + int'(P);
            hs_n <= hs_n + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y, output bit ok);
        a = x; b = y; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (p_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid: got %b want 0", p_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (P !== 16'd0) begin errors++; $display("FAIL reset_P: got %0d want 0", P); end
    endtask

    task automatic test_products;
        logic [7:0] ta[4] = '{8'd13, 8'd255, 8'd0, 8'd200};
        logic [7:0] tb[4] = '{8'd11, 8'd255, 8'd200, 8'd0};
        bit ok;
        int cyc;
        p_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            send(ta[t], tb[t], ok);
            exp_q.push_back(16'(ta[t]) * 16'(tb[t]));
            checks++; if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL prod%0d_accept: ok=%b busy=%b in_ready=%b want 1/1/0", t, ok, busy, in_ready); end
            wait_valid(cyc);
            checks++; if (cyc !== 9) begin errors++; $display("FAIL prod%0d_latency: got %0d want 9", t, cyc); end
            want = exp_q.pop_front();
            checks++; if (P !== want) begin errors++; $display("FAIL prod%0d_P: got %0d want %0d", t, P, want); end
            @(posedge clk); #1;
            checks++; if (p_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL prod%0d_release: p_valid=%b in_ready=%b want 0/1", t, p_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int cyc, acc0, hs0;
        p_ready = 1'b0;
        send(8'd7, 8'd9, ok);
        exp_q.push_back(16'd63);
        wait_valid(cyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL bp_latency: got %0d want 9", cyc); end
        want = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (P !== want || p_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: P=%0d p_valid=%b want %0d/1", i, P, p_valid, want); end
        end
        acc0 = acc; hs0 = hs_n;
        p_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: p_valid=%b want 0", p_valid); end
        checks++; if (hs_n - hs0 !== 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", hs_n - hs0); end
        checks++; if (acc - acc0 !== 63) begin errors++; $display("FAIL bp_acc: got %0d want 63", acc - acc0); end
    endtask

    task automatic test_overlap;
        bit ok;
        int cyc;
        p_ready = 1'b1;
        send(8'd3, 8'd4, ok);
        exp_q.push_back(16'd12);
        @(posedge clk); #1;
        a = 8'd5; b = 8'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ov_ignore: in_ready=%b busy=%b want 0/1", in_ready, busy); end
        in_valid = 1'b1;
        wait_valid(cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL ov_latency: got %0d want 7", cyc); end
        want = exp_q.pop_front();
        checks++; if (P !== want) begin errors++; $display("FAIL ov_first_P: got %0d want %0d", P, want); end
        @(posedge clk); #1;
        checks++; if (p_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ov_no_bypass: p_valid=%b in_ready=%b busy=%b want 0/1/0", p_valid, in_ready, busy); end
        exp_q.push_back(16'd25);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ov_accept: in_ready=%b busy=%b want 0/1", in_ready, busy); end
        wait_valid(cyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL ov2_latency: got %0d want 9", cyc); end
        want = exp_q.pop_front();
        checks++; if (P !== want) begin errors++; $display("FAIL ov2_P: got %0d want %0d", P, want); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort;
        bit ok, seen;
        int cyc;
        p_ready = 1'b1;
        send(8'd100, 8'd3, ok);
        exp_q.push_back(16'd300);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || p_valid !== 1'b0 || P !== 16'd0) begin errors++; $display("FAIL abort_outputs: in_ready=%b busy=%b p_valid=%b P=%0d want 1/0/0/0", in_ready, busy, p_valid, P); end
        exp_q.delete();
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen |= p_valid; end
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; seen |= p_valid; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_pulse: p_valid seen=%b want 0", seen); end
        send(8'd2, 8'd2, ok);
        exp_q.push_back(16'd4);
        wait_valid(cyc);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL abort_after_latency: got %0d want 9", cyc); end
        want = exp_q.pop_front();
        checks++; if (P !== want) begin errors++; $display("FAIL abort_after_P: got %0d want %0d", P, want); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; p_ready = 1'b1; a = '0; b = '0;
        repeat (2) begin @(posedge clk); #1; end
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_products;
        test_backpressure;
        test_overlap;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
